// File: rtl/cache_refill_arbiter.sv
// Round-robin cache line refill engine: grants one of NUM_CH channels, reads
// LINE_WORDS consecutive words from the base or ext SRAM and returns the line.
module cache_refill_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int LINE_WORDS  = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*32-1:0]     req_addr,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [32*LINE_WORDS-1:0] line_data,
  output logic                     base_ram_ce_n,
  output logic                     base_ram_oe_n,
  output logic                     base_ram_we_n,
  output logic [19:0]              base_ram_addr,
  input  logic [31:0]              base_ram_rdata,
  output logic                     ext_ram_ce_n,
  output logic                     ext_ram_oe_n,
  output logic                     ext_ram_we_n,
  output logic [19:0]              ext_ram_addr,
  input  logic [31:0]              ext_ram_rdata
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW_W = $clog2(LINE_WORDS);
  localparam int WT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, RET} state_t;

  state_t          state_reg, state_next;
  logic [CH_W-1:0] grant_reg, grant_next;
  logic [CH_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic            bank_reg, bank_next;
  logic [19:0]     line_base_reg, line_base_next;
  logic [LW_W-1:0] load_cnt_reg, load_cnt_next;
  logic [WT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [19:0]     base_addr_reg, base_addr_next;
  logic [19:0]     ext_addr_reg, ext_addr_next;

  logic            found;
  logic [CH_W-1:0] pick;
  logic [31:0]     pick_addr;
  logic [19:0]     new_base;
  logic [19:0]     next_word;
  logic [31:0]     rdata_sel;
  logic            active;
  logic            unused_addr_bits;

  // First asserted channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req_valid[CH_W'((int'(rr_ptr_reg) + k) % NUM_CH)]) begin
        found = 1'b1;
        pick  = CH_W'((int'(rr_ptr_reg) + k) % NUM_CH);
      end
    end
  end

  assign pick_addr        = req_addr[32*pick +: 32];
  assign new_base         = {pick_addr[21:2+LW_W], {LW_W{1'b0}}};
  assign next_word        = line_base_reg + 20'(load_cnt_reg) + 20'd1;
  assign unused_addr_bits = ^{pick_addr[31:23], pick_addr[2 +: LW_W], pick_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      bank_reg      <= 1'b0;
      line_base_reg <= '0;
      load_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      base_addr_reg <= '0;
      ext_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      bank_reg      <= bank_next;
      line_base_reg <= line_base_next;
      load_cnt_reg  <= load_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      base_addr_reg <= base_addr_next;
      ext_addr_reg  <= ext_addr_next;
    end
  end

  // The bank address register is loaded on entry to REQ so it is valid in REQ.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    bank_next      = bank_reg;
    line_base_next = line_base_reg;
    load_cnt_next  = load_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    base_addr_next = base_addr_reg;
    ext_addr_next  = ext_addr_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next     = pick;
          bank_next      = pick_addr[22];
          line_base_next = new_base;
          load_cnt_next  = '0;
          if (pick_addr[22]) ext_addr_next = new_base;
          else               base_addr_next = new_base;
          state_next     = REQ;
        end
      end
      REQ: begin
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (wait_cnt_reg == WT_W'(WAIT_CYCLES - 1)) state_next = LOAD;
      end
      LOAD: begin
        if (load_cnt_reg == LW_W'(LINE_WORDS - 1)) begin
          state_next = RET;
        end else begin
          load_cnt_next = load_cnt_reg + 1'b1;
          if (bank_reg) ext_addr_next = next_word;
          else          base_addr_next = next_word;
          state_next    = REQ;
        end
      end
      RET: begin
        rr_ptr_next = (grant_reg == CH_W'(NUM_CH - 1)) ? '0 : grant_reg + 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign active        = (state_reg == REQ) || (state_reg == WAIT) || (state_reg == LOAD);
  assign base_ram_ce_n = !(active && !bank_reg);
  assign base_ram_oe_n = !(active && !bank_reg);
  assign base_ram_we_n = 1'b1;
  assign base_ram_addr = base_addr_reg;
  assign ext_ram_ce_n  = !(active && bank_reg);
  assign ext_ram_oe_n  = !(active && bank_reg);
  assign ext_ram_we_n  = 1'b1;
  assign ext_ram_addr  = ext_addr_reg;
  assign rdata_sel     = bank_reg ? ext_ram_rdata : base_ram_rdata;

  always_comb begin
    req_ready = '0;
    if (state_reg == RET) req_ready[grant_reg] = 1'b1;
  end

  // Line buffer: one register per word, doubling as the line_data output.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
      logic [31:0] word_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word_reg <= '0;
        else if (state_reg == LOAD && load_cnt_reg == LW_W'(gi))
          word_reg <= rdata_sel;
      end
      assign line_data[gi*32 +: 32] = word_reg;
    end
  endgenerate
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: default instance plus a 3-channel, 8-word,
// 1-wait instance, with scoreboards checking every returned line.
module tb_cache_refill_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Default instance
  logic [1:0]   a_valid;
  logic [63:0]  a_addr;
  logic [1:0]   a_ready;
  logic [127:0] a_line;
  logic         a_bce, a_boe, a_bwe, a_ece, a_eoe, a_ewe;
  logic [19:0]  a_baddr, a_eaddr;
  logic [31:0]  a_brd, a_erd;

  // Sweep instance
  logic [2:0]   b_valid;
  logic [95:0]  b_addr;
  logic [2:0]   b_ready;
  logic [255:0] b_line;
  logic         b_bce, b_boe, b_bwe, b_ece, b_eoe, b_ewe;
  logic [19:0]  b_baddr, b_eaddr;
  logic [31:0]  b_brd, b_erd;

  // SRAM models: base word n holds n, ext word n holds 0xE000_0000 | n.
  assign a_brd = {12'h000, a_baddr};
  assign a_erd = {12'hE00, a_eaddr};
  assign b_brd = {12'h000, b_baddr};
  assign b_erd = {12'hE00, b_eaddr};

  cache_refill_arbiter #(.NUM_CH(2), .LINE_WORDS(4), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_addr(a_addr),
    .req_ready(a_ready), .line_data(a_line),
    .base_ram_ce_n(a_bce), .base_ram_oe_n(a_boe), .base_ram_we_n(a_bwe),
    .base_ram_addr(a_baddr), .base_ram_rdata(a_brd),
    .ext_ram_ce_n(a_ece), .ext_ram_oe_n(a_eoe), .ext_ram_we_n(a_ewe),
    .ext_ram_addr(a_eaddr), .ext_ram_rdata(a_erd)
  );

  cache_refill_arbiter #(.NUM_CH(3), .LINE_WORDS(8), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_addr(b_addr),
    .req_ready(b_ready), .line_data(b_line),
    .base_ram_ce_n(b_bce), .base_ram_oe_n(b_boe), .base_ram_we_n(b_bwe),
    .base_ram_addr(b_baddr), .base_ram_rdata(b_brd),
    .ext_ram_ce_n(b_ece), .ext_ram_oe_n(b_eoe), .ext_ram_we_n(b_ewe),
    .ext_ram_addr(b_eaddr), .ext_ram_rdata(b_erd)
  );

  typedef struct {
    int           ch;
    logic [255:0] line;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  bit   we_low_seen   = 1'b0;
  bit   both_ce_seen  = 1'b0;
  bit   ctl_mismatch  = 1'b0;

  function automatic logic [255:0] exp_line(input logic [31:0] a, input int lw);
    logic [19:0] base;
    logic [31:0] w;
    exp_line = '0;
    base = a[21:2] & ~20'(lw - 1);
    for (int k = 0; k < lw; k++) begin
      w = {12'h000, base + 20'(k)};
      if (a[22]) w[31:20] = 12'hE00;
      exp_line[k*32 +: 32] = w;
    end
  endfunction

  // Scoreboards: every ready pulse pops the next expected (channel, line).
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (a_bwe !== 1'b1 || a_ewe !== 1'b1 || b_bwe !== 1'b1 || b_ewe !== 1'b1) we_low_seen = 1'b1;
      if ((a_bce === 1'b0 && a_ece === 1'b0) || (b_bce === 1'b0 && b_ece === 1'b0)) both_ce_seen = 1'b1;
      if (a_bce !== a_boe || a_ece !== a_eoe || b_bce !== b_boe || b_ece !== b_eoe) ctl_mismatch = 1'b1;
      if (a_ready !== 2'b00) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_ready: ready=%b with nothing outstanding", a_ready);
        end else begin
          ea = q_a.pop_front();
          if (a_ready !== 2'(1 << ea.ch) || a_line !== ea.line[127:0]) begin
            errors++;
            $display("FAIL a_line: got ready=%b line=%h, expected ready=%b line=%h",
                     a_ready, a_line, 2'(1 << ea.ch), ea.line[127:0]);
          end
          $display("A refill: ch%0d line=%h", ea.ch, a_line);
        end
      end
      if (b_ready !== 3'b000) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_ready: ready=%b with nothing outstanding", b_ready);
        end else begin
          eb = q_b.pop_front();
          if (b_ready !== 3'(1 << eb.ch) || b_line !== eb.line) begin
            errors++;
            $display("FAIL b_line: got ready=%b line=%h, expected ready=%b line=%h",
                     b_ready, b_line, 3'(1 << eb.ch), eb.line);
          end
          $display("B refill: ch%0d line=%h", eb.ch, b_line);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    a_valid = '0; a_addr = '0; b_valid = '0; b_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_ready !== 2'b00 || b_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b, expected 0", a_ready, b_ready);
    end
    checks++;
    if (a_line !== '0 || b_line !== '0) begin
      errors++; $display("FAIL reset_line: got a=%h b=%h, expected 0", a_line, b_line);
    end
    checks++;
    if ({a_bce, a_boe, a_bwe, a_ece, a_eoe, a_ewe} !== 6'b111111) begin
      errors++; $display("FAIL reset_ctl_a: got %b, expected 111111", {a_bce, a_boe, a_bwe, a_ece, a_eoe, a_ewe});
    end
    checks++;
    if ({b_bce, b_boe, b_bwe, b_ece, b_eoe, b_ewe} !== 6'b111111) begin
      errors++; $display("FAIL reset_ctl_b: got %b, expected 111111", {b_bce, b_boe, b_bwe, b_ece, b_eoe, b_ewe});
    end
    checks++;
    if (a_baddr !== 20'h0 || a_eaddr !== 20'h0 || b_baddr !== 20'h0 || b_eaddr !== 20'h0) begin
      errors++; $display("FAIL reset_addr: got %h %h %h %h, expected 0", a_baddr, a_eaddr, b_baddr, b_eaddr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_base();
    logic [19:0] seen[$];
    int  lat = 0, ce_low = 0;
    bit  got = 1'b0, other = 1'b0, ok;
    a_addr[31:0] = 32'h0000_0104;
    a_valid = 2'b01;
    q_a.push_back('{0, exp_line(32'h0000_0104, 4)});
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clk); #1;
      if (a_bce === 1'b0) begin
        ce_low++;
        if (seen.size() == 0 || seen[$] !== a_baddr) seen.push_back(a_baddr);
      end
      if (a_ece !== 1'b1) other = 1'b1;
      if (a_ready !== 2'b00) begin got = 1'b1; lat = n; a_valid = 2'b00; end
    end
    checks++;
    if (!got || lat != 17) begin
      errors++; $display("FAIL single_latency: got %0d (seen=%0d), expected 17", lat, got);
    end
    ok = (seen.size() == 4);
    for (int k = 0; k < 4 && ok; k++) if (seen[k] !== 20'h40 + 20'(k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_addr_seq: got %0d addresses, expected 40,41,42,43", seen.size());
    end
    checks++;
    if (ce_low != 16) begin
      errors++; $display("FAIL single_ce_cycles: got %0d, expected 16", ce_low);
    end
    checks++;
    if (other) begin
      errors++; $display("FAIL single_ext_idle: ext ce_n went low, expected it to stay 1");
    end
    @(posedge clk); #1;
    checks++;
    if (a_ready !== 2'b00) begin
      errors++; $display("FAIL single_pulse_width: got ready=%b, expected 00", a_ready);
    end
    checks++;
    if (a_line !== 128'h00000043_00000042_00000041_00000040) begin
      errors++; $display("FAIL single_line_hold: got %h, expected 43/42/41/40", a_line);
    end
  endtask

  task automatic test_ext_bank();
    logic [19:0] seen[$];
    int  lat = 0;
    bit  got = 1'b0, other = 1'b0, ok;
    a_addr[63:32] = 32'h0040_0010;
    a_valid = 2'b10;
    q_a.push_back('{1, exp_line(32'h0040_0010, 4)});
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clk); #1;
      if (a_ece === 1'b0 && (seen.size() == 0 || seen[$] !== a_eaddr)) seen.push_back(a_eaddr);
      if (a_bce !== 1'b1 || a_boe !== 1'b1) other = 1'b1;
      if (a_ready !== 2'b00) begin got = 1'b1; lat = n; a_valid = 2'b00; end
    end
    checks++;
    if (!got || lat != 17) begin
      errors++; $display("FAIL ext_latency: got %0d (seen=%0d), expected 17", lat, got);
    end
    ok = (seen.size() == 4);
    for (int k = 0; k < 4 && ok; k++) if (seen[k] !== 20'h4 + 20'(k)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ext_addr_seq: got %0d addresses, expected 4,5,6,7", seen.size());
    end
    checks++;
    if (other) begin
      errors++; $display("FAIL ext_base_idle: base ce_n/oe_n went low, expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int times[$];
    bit wide = 1'b0, ok;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_addr = {32'h0040_0300, 32'h0000_0200};
    q_a.push_back('{0, exp_line(32'h0000_0200, 4)});
    q_a.push_back('{1, exp_line(32'h0040_0300, 4)});
    q_a.push_back('{0, exp_line(32'h0000_0200, 4)});
    q_a.push_back('{1, exp_line(32'h0040_0300, 4)});
    a_valid = 2'b11;
    for (int n = 1; n <= 200 && times.size() < 4; n++) begin
      @(posedge clk); #1;
      if (a_ready !== 2'b00) begin
        if (times.size() > 0 && times[$] == n - 1) wide = 1'b1;
        times.push_back(n);
        if (times.size() == 4) a_valid = 2'b00;
      end
    end
    ok = (times.size() == 4) && (times[0] == 17);
    for (int k = 1; k < times.size() && ok; k++) if (times[k] - times[k-1] != 18) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL contention_timing: got %0d grants, first at %0d, expected 4 at 17 spaced 18",
                         times.size(), (times.size() > 0) ? times[0] : -1);
    end
    checks++;
    if (wide) begin
      errors++; $display("FAIL contention_pulse: ready held high 2+ cycles, expected 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int  lat = 0;
    bit  got = 1'b0, reached = 1'b0, stray = 1'b0;
    a_addr[31:0] = 32'h0000_0104;
    a_valid = 2'b01;
    q_a.push_back('{0, exp_line(32'h0000_0104, 4)});
    for (int n = 1; n <= 40 && !reached; n++) begin
      @(posedge clk); #1;
      if (a_bce === 1'b0 && a_baddr === 20'h42) reached = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    a_valid = 2'b00;
    q_a.delete();
    #1;
    checks++;
    if (!reached || {a_bce, a_boe, a_ece, a_eoe} !== 4'b1111 || a_ready !== 2'b00) begin
      errors++; $display("FAIL midreset_ctl: got ctl=%b ready=%b (reached=%0d), expected 1111/00",
                         {a_bce, a_boe, a_ece, a_eoe}, a_ready, reached);
    end
    checks++;
    if (a_baddr !== 20'h0 || a_line !== '0) begin
      errors++; $display("FAIL midreset_state: got addr=%h line=%h, expected 0", a_baddr, a_line);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (a_ready !== 2'b00) stray = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (a_ready !== 2'b00) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL midreset_noready: got a ready pulse, expected none");
    end
    a_valid = 2'b01;
    q_a.push_back('{0, exp_line(32'h0000_0104, 4)});
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clk); #1;
      if (a_ready !== 2'b00) begin got = 1'b1; lat = n; a_valid = 2'b00; end
    end
    checks++;
    if (!got || lat != 17) begin
      errors++; $display("FAIL midreset_rerequest: got latency %0d (seen=%0d), expected 17", lat, got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int times[$];
    bit ok;
    b_addr = {32'h0000_0100, 32'h0040_0044, 32'h0000_0020};
    q_b.push_back('{0, exp_line(32'h0000_0020, 8)});
    q_b.push_back('{1, exp_line(32'h0040_0044, 8)});
    q_b.push_back('{2, exp_line(32'h0000_0100, 8)});
    q_b.push_back('{0, exp_line(32'h0000_0020, 8)});
    b_valid = 3'b111;
    for (int n = 1; n <= 300 && times.size() < 4; n++) begin
      @(posedge clk); #1;
      if (b_ready !== 3'b000) begin
        times.push_back(n);
        if (times.size() == 4) b_valid = 3'b000;
      end
    end
    checks++;
    if (times.size() == 0 || times[0] != 25) begin
      errors++; $display("FAIL sweep_latency: got %0d, expected 25", (times.size() > 0) ? times[0] : -1);
    end
    ok = (times.size() == 4);
    for (int k = 1; k < times.size() && ok; k++) if (times[k] - times[k-1] != 26) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL sweep_grants: got %0d grants, expected 4 spaced 26", times.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_static();
    checks++;
    if (we_low_seen) begin
      errors++; $display("FAIL we_n_static: got we_n=0 at some point, expected constant 1");
    end
    checks++;
    if (both_ce_seen) begin
      errors++; $display("FAIL bank_exclusive: got both ce_n low together, expected one bank at most");
    end
    checks++;
    if (ctl_mismatch) begin
      errors++; $display("FAIL ce_oe_pair: got ce_n != oe_n on a bank, expected them equal");
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d outstanding, expected 0", q_a.size(), q_b.size());
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_single_base();
    test_ext_bank();
    test_contention();
    test_reset_mid();
    test_sweep();
    repeat (3) @(posedge clk);
    #1;
    test_static();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Parametrised line-refill engine between the instruction/data caches and the two on-board SRAMs (base, ext). Accepts cache-line read requests from NUM_CH cache channels, grants one at a time by round-robin, issues LINE_WORDS sequential word reads to the SRAM bank selected by the address, and assembles them into one line. It then returns the line with a one-cycle ready pulse to the granted channel. Read-only: refills only; write-back is handled elsewhere.

## Interface
- NUM_CH, 2, number of requesting channels (ch0 = ICache, ch1 = DCache by convention); ≥ 1
- LINE_WORDS, 4, 32-bit words per cache line; power of two, ≥ 2
- WAIT_CYCLES, 2, SRAM access wait cycles per word; ≥ 1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_CH  per-channel refill request; held until that channel's ready
- req_addr  in  NUM_CH*32  per-channel byte address, channel i at [i*32 +: 32]; held with valid
- req_ready  out  NUM_CH  one-cycle pulse to the granted channel: line_data valid
- line_data  out  32*LINE_WORDS  assembled line; word k at [k*32 +: 32]
- base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  1 each  base SRAM controls, active-low
- base_ram_addr  out  20  base SRAM word address
- base_ram_rdata  in  32  base SRAM read data
- ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n  out  1 each  ext SRAM controls, active-low
- ext_ram_addr  out  20  ext SRAM word address
- ext_ram_rdata  in  32  ext SRAM read data

## Operation
- States: IDLE, REQ, WAIT, LOAD, RET.
- IDLE: if any req_valid, grant the first asserted channel searching from rr_ptr upward (mod NUM_CH).
  - Latch grant index, bank = req_addr[22] (0 base, 1 ext), line base word address = req_addr[21:2] with low log2(LINE_WORDS) bits cleared.
  - Clear load_cnt. Go to REQ.
  - Otherwise stay in IDLE.
- REQ: drive selected bank addr = line base + load_cnt; ce_n = oe_n = 0. Clear wait_cnt. Go to WAIT.
- WAIT: hold address and controls. Increment wait_cnt. When wait_cnt == WAIT_CYCLES-1, go to LOAD.
- LOAD: hold address and controls. Write the selected bank's rdata into line buffer word load_cnt at the clock edge.
  - If load_cnt == LINE_WORDS-1, go to RET.
  - Otherwise increment load_cnt and go to REQ.
- RET: req_ready[grant] = 1 for this cycle only; controls deasserted. Set rr_ptr = grant+1 mod NUM_CH. Go to IDLE.
- line_data is the line buffer. It holds its value from RET until the next LOAD overwrites word 0.
- we_n of both banks is constant 1. The unselected bank's ce_n/oe_n stay 1 throughout. Each bank's addr holds its last driven value.
- Address bits [31:23] and [1:0] are ignored. Wrap within the line never happens because the base is line-aligned.
- A channel must drop req_valid in the cycle after its ready. A channel that keeps valid high is re-granted only per round-robin.
- req_valid deasserted mid-refill: the refill completes and ready is still pulsed. A requester must not withdraw.

## Timing
- Reset (async assert, sync-safe deassert):
  - state = IDLE, rr_ptr = 0, req_ready = 0, line_data = 0
  - all ce_n/oe_n/we_n = 1, both ram_addr = 0, counters = 0
- Per word: REQ 1 + WAIT WAIT_CYCLES + LOAD 1 = WAIT_CYCLES+2 cycles of ce_n/oe_n low.
  - Controls stay low continuously across all words of one line.
- Latency: valid first sampled high in IDLE in cycle 0 gives req_ready high in cycle 1 + LINE_WORDS*(WAIT_CYCLES+2).
  - Defaults: cycle 17.
- Minimum gap between back-to-back grants: 1 IDLE cycle after RET.
- Simultaneous valid on several channels: the round-robin order decides; losers wait with no lost request.
- rst asserted mid-refill: immediate return to IDLE, controls high, no ready pulse, partial line discarded, rr_ptr = 0. Requesters re-issue.

## Test plan
- Single request: ch0 valid, addr 0x0000_0104, bank 0 with SRAM word n = n.
  - base_ram_addr steps 0x40, 0x41, 0x42, 0x43.
  - ready[0] pulses in cycle 17.
  - line_data = {0x43, 0x42, 0x41, 0x40}.
- Ext bank: ch1 addr 0x0040_0010 → only ext_ram_ce_n toggles, ext_ram_addr 4..7; base controls stay 1; ready[1] only.
- Contention: ch0 and ch1 valid from reset, both re-requesting continuously → grants ch0, ch1, ch0, ch1; each ready exactly one cycle.
- Reset mid-refill: assert rst during the third word's WAIT → outputs return to reset values the same cycle; no ready. Re-request after release completes normally.
- Parameter sweep: NUM_CH=3, LINE_WORDS=8, WAIT_CYCLES=1.
  - Latency 25 cycles.
  - Round-robin rotates over ch0→ch1→ch2.
  - we_n is never 0 in any configuration.
